mem_bus_arbiter: RTL
====================

# mem_bus_arbiter

Two-port arbiter that shares the single synchronous TempRam word memory between two bus masters: the TrashbinCore memory bus (port A) and a second requester such as a program loader or debug DMA (port B). It sequences each access through a three-cycle issue/complete state machine and returns per-port acknowledge, which drives the core's ReadOK/WriteOK inputs. It also flags addresses outside the RAM window instead of aliasing them.

## Interface
- ADDR_WIDTH, 14, RAM word-address bits; bus addresses use the full 32 bits.
- DATA_WIDTH, 32, data bus width.

- CoreClock  in  1  sole clock, rising edge.
- CoreResetN  in  1  synchronous reset, active low.
- AReq / BReq  in  1  transaction request, held until the matching Ack.
- AWrite / BWrite  in  1  1 = write, 0 = read; stable while Req is high.
- AAddr / BAddr  in  32  word address; stable while Req is high.
- AWData / BWData  in  DATA_WIDTH  write data; stable while Req is high.
- AAck / BAck  out  1  one-cycle completion pulse; wired to the core's ReadOK/WriteOK.
- AErr / BErr  out  1  valid with Ack; 1 = address out of range.
- ARData / BRData  out  DATA_WIDTH  read data; valid with Ack, 0 otherwise.
- RamAddress  out  ADDR_WIDTH  TempRam address.
- RamWData  out  DATA_WIDTH  TempRam write data.
- RamWrite  out  1  TempRam write enable.
- RamRData  in  DATA_WIDTH  TempRam q. Address is registered in the RAM and q is valid in the cycle after the address edge.
- Owner  out  1  current or last grant: 0 = A, 1 = B.
- Busy  out  1  high when the FSM is not IDLE.

## Operation
- States: IDLE, ISSUE, DONE.
- **IDLE**
  - If no Req is high, remain in IDLE.
  - If exactly one Req is high, grant that port.
  - If both are high, grant the port that was not granted last (round-robin).
  - On a grant: latch the owner and go to ISSUE.
- **ISSUE**
  - RamAddress = owner Addr[ADDR_WIDTH-1:0]; RamWData = owner WData.
  - RamWrite = owner Write AND in-range.
  - In-range means owner Addr[31:ADDR_WIDTH] == 0.
  - Always go to DONE.
- **DONE**
  - Owner Ack = 1.
  - Owner Err = !in-range (in-range as latched in ISSUE).
  - Owner RData = RamRData for an in-range read, else 0.
  - Always go to IDLE. Req inputs are ignored in DONE.
- The requester must drop Req, or present a new transaction, in the cycle after Ack. A Req still high in IDLE is treated as a new transaction.
- The non-owner sees Ack = 0, Err = 0, RData = 0.
- Out-of-range write: no RAM write, Err = 1. Out-of-range read: RData = 0, Err = 1.
- Last-grant pointer updates on every grant. It resets to B, so A wins the first tie.
- RamAddress, RamWData and RamWrite are 0 outside ISSUE.

## Timing
- Reset (CoreResetN low at an edge):
  - State becomes IDLE; last-grant pointer becomes B; Owner = 0.
  - All Ack, Err, RData, RamWrite and Busy are 0 from the following cycle.
- Latency, with Req first seen high in IDLE in cycle n:
  - cycle n+1 is ISSUE;
  - cycle n+2 is DONE, with Ack high;
  - cycle n+3 is IDLE.
- Throughput is one transaction per 3 cycles.
- Back-to-back, both ports continuously requesting: grants alternate A, B, A, B, …, each taking 3 cycles. Neither port waits more than 6 cycles from IDLE.
- Reset mid-transaction:
  - The pending transaction is aborted and no Ack is produced.
  - A write whose ISSUE cycle coincides with the reset edge may land in RAM. The requester must reissue.
- Req arriving during ISSUE or DONE is held by the requester and arbitrated at the next IDLE.
- Outputs are combinational decodes of the registered state, the owner, and the held request inputs. There are no paths from Req to Ack within the same cycle.

## Test plan
- Single read:
  - Stimulus: preload RAM[0x0010] = 0xDEADBEEF; AReq with AAddr = 0x10, AWrite = 0 in cycle 0.
  - Response: RamAddress = 0x0010 in cycle 1; AAck = 1, ARData = 0xDEADBEEF, AErr = 0 in cycle 2; BAck = 0 throughout.
- Write then read:
  - Stimulus: B writes 0x12345678 to 0x3FFF, then reads 0x3FFF.
  - Response: RamWrite = 1 only in the write's ISSUE cycle; the read returns 0x12345678 on BRData with BAck.
- Tie and round-robin:
  - Stimulus: AReq and BReq held high from reset release for 12 cycles.
  - Response: Acks in order A, B, A, B at cycles 2, 5, 8, 11; Owner toggles accordingly.
- Out of range:
  - Stimulus: A writes 0xFFFFFFFF to address 0x00004000.
  - Response: RamWrite stays 0; AAck = 1 with AErr = 1; a subsequent read of 0x0000 returns the unchanged value.
- Reset mid-operation:
  - Stimulus: A read granted; CoreResetN low during ISSUE.
  - Response: no AAck; Busy = 0 next cycle; after release, a new AReq completes normally in 3 cycles.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Shares one synchronous TempRam between the core bus (port A) and a
// secondary requester (port B). Each access runs IDLE -> ISSUE -> DONE,
// with round-robin arbitration on ties and out-of-range detection on the
// upper address bits so that accesses outside the RAM window never alias.
module mem_bus_arbiter #(
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  CoreClock,
    input  logic                  CoreResetN,

    input  logic                  AReq,
    input  logic                  AWrite,
    input  logic [31:0]           AAddr,
    input  logic [DATA_WIDTH-1:0] AWData,
    output logic                  AAck,
    output logic                  AErr,
    output logic [DATA_WIDTH-1:0] ARData,

    input  logic                  BReq,
    input  logic                  BWrite,
    input  logic [31:0]           BAddr,
    input  logic [DATA_WIDTH-1:0] BWData,
    output logic                  BAck,
    output logic                  BErr,
    output logic [DATA_WIDTH-1:0] BRData,

    output logic [ADDR_WIDTH-1:0] RamAddress,
    output logic [DATA_WIDTH-1:0] RamWData,
    output logic                  RamWrite,
    input  logic [DATA_WIDTH-1:0] RamRData,

    output logic                  Owner,
    output logic                  Busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_owner;      // 0 = A, 1 = B; visible on Owner
    logic                  r_last;       // round-robin pointer, resets to B
    logic                  r_in_range;
    logic                  r_write;
    logic                  r_ack;
    logic                  r_err;
    logic                  r_rd_ok;      // DONE of an in-range read
    logic [ADDR_WIDTH-1:0] r_ram_addr;
    logic [DATA_WIDTH-1:0] r_ram_wdata;
    logic                  r_ram_write;

    logic                  w_grant_valid;
    logic                  w_grant_b;
    logic                  w_sel_write;
    logic [31:0]           w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;
    logic                  w_sel_in_range;
    logic [DATA_WIDTH-1:0] w_rdata;

    // Arbitration: single requester wins outright, ties go to the port not granted last
    always_comb begin
        w_grant_valid = AReq | BReq;
        w_grant_b     = 1'b0;
        if (AReq && BReq) begin
            w_grant_b = ~r_last;
        end else begin
            w_grant_b = BReq;
        end
        w_sel_write    = w_grant_b ? BWrite : AWrite;
        w_sel_addr     = w_grant_b ? BAddr  : AAddr;
        w_sel_wdata    = w_grant_b ? BWData : AWData;
        w_sel_in_range = (w_sel_addr[31:ADDR_WIDTH] == '0);
    end

    // Transaction FSM; RAM strobes are loaded on grant so they are live exactly in ISSUE,
    // and Ack/Err are loaded on ISSUE exit so they are live exactly in DONE
    always_ff @(posedge CoreClock) begin
        if (!CoreResetN) begin
            r_state     <= ST_IDLE;
            r_owner     <= 1'b0;
            r_last      <= 1'b1;
            r_in_range  <= 1'b0;
            r_write     <= 1'b0;
            r_ack       <= 1'b0;
            r_err       <= 1'b0;
            r_rd_ok     <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_ram_write <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_ack   <= 1'b0;
                    r_err   <= 1'b0;
                    r_rd_ok <= 1'b0;
                    if (w_grant_valid) begin
                        r_owner     <= w_grant_b;
                        r_last      <= w_grant_b;
                        r_in_range  <= w_sel_in_range;
                        r_write     <= w_sel_write;
                        r_ram_addr  <= w_sel_addr[ADDR_WIDTH-1:0];
                        r_ram_wdata <= w_sel_wdata;
                        r_ram_write <= w_sel_write & w_sel_in_range;
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_ram_addr  <= '0;
                    r_ram_wdata <= '0;
                    r_ram_write <= 1'b0;
                    r_ack       <= 1'b1;
                    r_err       <= ~r_in_range;
                    r_rd_ok     <= ~r_write & r_in_range;
                    r_state     <= ST_DONE;
                end
                ST_DONE: begin
                    r_ack   <= 1'b0;
                    r_err   <= 1'b0;
                    r_rd_ok <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_ram_addr  <= '0;
                    r_ram_wdata <= '0;
                    r_ram_write <= 1'b0;
                    r_ack       <= 1'b0;
                    r_err       <= 1'b0;
                    r_rd_ok     <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    // RAM q is only valid in DONE, so read data is gated straight from it
    always_comb begin
        w_rdata = r_rd_ok ? RamRData : '0;
    end

    assign AAck       = r_ack & ~r_owner;
    assign BAck       = r_ack &  r_owner;
    assign AErr       = r_err & ~r_owner;
    assign BErr       = r_err &  r_owner;
    assign ARData     = r_owner ? '0 : w_rdata;
    assign BRData     = r_owner ? w_rdata : '0;

    assign RamAddress = r_ram_addr;
    assign RamWData   = r_ram_wdata;
    assign RamWrite   = r_ram_write;

    assign Owner      = r_owner;
    assign Busy       = (r_state != ST_IDLE);

endmodule
